rtmq_rand_arbiter: RTL
======================

// Module: rtmq_rand_arbiter
// PURPOSE
//  Shares one combined-Tausworthe random source (three 64-bit components z1/z2/z3, output = low W_REG bits of z1^z2^z3) among N_REQ peripheral requesters.
//  Hands out words through a round-robin req/ack handshake. Each word goes to exactly one requester.
//  The generator steps only on consumption, so the word sequence is fixed by the seed alone, independent of idle time.
//  Sits between the RTMQ core's random-number consumers and the Tausworthe datapath.
// PARAMETERS
//  N_REQ   4    number of requesters, 2..16
//  WARM    64   generator steps discarded after reset/reseed, >=1
//  W_REG   (RTMQ_Peripheral.v)  width of delivered word, <=64
// PORTS
//  clk      in   1       system clock
//  rst      in   1       synchronous, active-high reset
//  req      in   N_REQ   level request per requester; held until its ack
//  ack      out  N_REQ   one-hot, one-cycle pulse: rnd_dat valid for that requester
//  rnd_dat  out  W_REG   delivered random word, registered, valid when |ack
//  busy     out  1       1 while warming up; requests not served
//  seed_we  in   1       [RTMQ_RAND_RESEED_EN only] seed write strobe
//  seed_sel in   2       [RTMQ_RAND_RESEED_EN only] 0:z1 1:z2 2:z3 3:ignored
//  seed_dat in   64      [RTMQ_RAND_RESEED_EN only] seed value
// BEHAVIOUR
//  Interface: one clock, clk; reset rst is synchronous and active-high.
//  Reset: z1/z2/z3 = 64'h45D0_00FF_FFF0_05FF / 64'hFFFC_BFFF_D800_0680 / 64'hFFDA_3500_00FE_95FF.
//    Also on reset: state=WARMUP, warm_cnt=0, ack=0, rnd_dat=0, busy=1, rr_ptr=0. Reset mid-operation aborts any grant and restarts warm-up.
//  Step (per component, when enabled):
//    z1<={z1[39:1], z1[58:34]^z1[63:39]}
//    z2<={z2[50:6], z2[44:26]^z2[63:45]}
//    z3<={z3[56:9], z3[39:24]^z3[63:48]}
//  FSM WARMUP: step every cycle, warm_cnt++. At warm_cnt==WARM-1 go SERVE; busy=0 from the next cycle. Exactly WARM steps are discarded.
//  FSM SERVE: if |req, grant the first set bit at or after rr_ptr (wrapping N_REQ-1 -> 0).
//    Next cycle: ack[g]=1, rnd_dat=(z1^z2^z3)[W_REG-1:0] sampled before the step, one step taken.
//    rr_ptr <= g+1 mod N_REQ. No request: no step, ack=0, rnd_dat holds its value.
//  Throughput: one word per cycle. Latency req->ack is 1 cycle when uncontended.
//    A requester still holding req after its ack is eligible again per round-robin.
//  ack never asserts in WARMUP. A req dropped before grant gets no ack; no word is consumed.
// CONFIGURATION
//  `RTMQ_RAND_RESEED_EN defined: seed ports exist. seed_we with seed_sel<3 loads that component on the next edge.
//    Then: state=WARMUP, warm_cnt=0, busy=1, ack=0 that cycle.
//    A seed write in the same cycle as a pending grant wins; the request stays pending.
//    seed_dat==0 loads that component's reset value instead (avoids the lock-up state).
//    seed_sel==3 is a no-op. seed_we together with rst: rst wins.
//  Not defined: no seed ports, seeds fixed at reset values, SERVE is left only on rst.
// STRUCTURE
//  Shared package include (RTMQ_Peripheral.v): W_REG, three reset seeds as localparams, state encoding WARMUP=0/SERVE=1.
//  Sub-module rtmq_taus_core: z1/z2/z3 regs, step enable, per-component load port (`RTMQ_RAND_RESEED_EN), comb word output.
//  Top holds the FSM, warm counter, round-robin picker, ack/rnd_dat registers.
// TESTING
//  Reset, req=4'b0001 held: busy=1 for 64 cycles. First ack[0] arrives the cycle after busy falls.
//    rnd_dat equals the word of a C model after 64 steps from the reset seeds.
//  req=4'b1111 held 8 cycles in SERVE: ack order 0,1,2,3,0,1,2,3. All 8 words distinct and equal to model words k..k+7.
//  Single requester with 10-cycle gaps between reqs: delivered sequence identical to the back-to-back sequence (no idle stepping).
//  req[2] pulsed 1 cycle while req[1] is granted: no ack[2], next model word delivered to the next requester.
//  rst asserted mid-SERVE with req=4'b0011: ack=0 next cycle, busy=1. The first word after rewarm equals the first word after power-on reset.
//  (RESEED_EN) seed_we, sel=0, dat=0 while req[3] held: no ack that cycle; busy=1 for 64 cycles.
//    Words then match the model from reset seeds with a 64-step warm-up. Repeat with dat=64'h1234_5678_9ABC_DEF0 against the model.

Source files
------------

// File: rtl/rtmq_rand_arbiter_pkg.sv
// Shared constants for the RTMQ random-word arbiter: word width, Tausworthe reset seeds, FSM encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rtmq_rand_arbiter_pkg;

  localparam int W_REG = 32;

  localparam logic [63:0] Z1_RST = 64'h45D0_00FF_FFF0_05FF;
  localparam logic [63:0] Z2_RST = 64'hFFFC_BFFF_D800_0680;
  localparam logic [63:0] Z3_RST = 64'hFFDA_3500_00FE_95FF;

  typedef enum logic {
    WARMUP = 1'b0,
    SERVE  = 1'b1
  } state_e;

  // An all-zero component never leaves zero, so a zero seed falls back to the reset value.
  function automatic logic [63:0] seed_or_rst(input logic [63:0] dat, input logic [63:0] rst_val);
    return (dat == 64'd0) ? rst_val : dat;
  endfunction

endpackage

// File: rtl/rtmq_rand_arbiter_if.sv
// Requester-side bundle of the random-word arbiter: level req, one-hot ack pulse, word, busy.
// Latency: ack/rnd_dat registered, one cycle after the granted req.
// Backpressure: req is held by the requester until its ack; busy means no service.
interface rtmq_rand_arbiter_if
  import rtmq_rand_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DAT_W = W_REG
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] ack;
  logic [DAT_W-1:0] rnd_dat;
  logic             busy;

  modport master (output req, input ack, input rnd_dat, input busy);
  modport slave  (input req, output ack, output rnd_dat, output busy);
endinterface

// File: rtl/rtmq_rand_arbiter_taus.sv
// Combined three-component Tausworthe generator; steps on i_step, optional per-component load (RTMQ_RAND_RESEED_EN).
// Latency: word is combinational from the current state; new state one edge after step/load.
// Backpressure: none; state holds whenever neither step nor load is asserted.
module rtmq_taus_core
  import rtmq_rand_arbiter_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_step,
`ifdef RTMQ_RAND_RESEED_EN
  input  logic [2:0]       i_load_en,
  input  logic [63:0]      i_load_dat,
`endif
  output logic [W_REG-1:0] o_word
);

  logic [63:0] r_z1, r_z2, r_z3;
  logic [63:0] w_mix;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_z1 <= Z1_RST;
      r_z2 <= Z2_RST;
      r_z3 <= Z3_RST;
    end else
`ifdef RTMQ_RAND_RESEED_EN
    if (|i_load_en) begin
      if (i_load_en[0]) r_z1 <= seed_or_rst(i_load_dat, Z1_RST);
      if (i_load_en[1]) r_z2 <= seed_or_rst(i_load_dat, Z2_RST);
      if (i_load_en[2]) r_z3 <= seed_or_rst(i_load_dat, Z3_RST);
    end else
`endif
    if (i_step) begin
      r_z1 <= {r_z1[39:1], r_z1[58:34] ^ r_z1[63:39]};
      r_z2 <= {r_z2[50:6], r_z2[44:26] ^ r_z2[63:45]};
      r_z3 <= {r_z3[56:9], r_z3[39:24] ^ r_z3[63:48]};
    end
  end

  assign w_mix  = r_z1 ^ r_z2 ^ r_z3;
  assign o_word = w_mix[W_REG-1:0];

endmodule

// File: rtl/rtmq_rand_arbiter.sv
// Round-robin arbiter handing Tausworthe words to N_REQ requesters; seed ports under RTMQ_RAND_RESEED_EN.
// Latency: ack and rnd_dat one cycle after an uncontended req; one word per cycle.
// Backpressure: generator steps only when a word is consumed; busy during WARM-step warm-up.
module rtmq_rand_arbiter
  import rtmq_rand_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WARM  = 64
)(
  input  logic                 i_clk,
  input  logic                 i_rst,
  rtmq_rand_arbiter_if.slave   bus
`ifdef RTMQ_RAND_RESEED_EN
  ,
  input  logic                 i_seed_we,
  input  logic [1:0]           i_seed_sel,
  input  logic [63:0]          i_seed_dat
`endif
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = (WARM > 1) ? $clog2(WARM) : 1;

  state_e             r_state, w_state_nxt;
  logic [CW-1:0]      r_warm_cnt;
  logic [PW-1:0]      r_rr;
  logic [N_REQ-1:0]   r_ack;
  logic [W_REG-1:0]   r_rnd;
  logic               w_warm_last, w_seed_wr, w_step, w_grant, w_gnt_vld;
  logic [PW-1:0]      w_gnt_idx;
  logic [N_REQ-1:0]   w_onehot;
  logic [W_REG-1:0]   w_word;

  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return PW'(s);
  endfunction

`ifdef RTMQ_RAND_RESEED_EN
  logic [2:0] w_load_en;
  assign w_seed_wr = i_seed_we && (i_seed_sel != 2'd3);
  assign w_load_en = w_seed_wr ? (3'b001 << i_seed_sel) : 3'b000;
`else
  assign w_seed_wr = 1'b0;
`endif

  rtmq_taus_core u_taus (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_step     (w_step),
`ifdef RTMQ_RAND_RESEED_EN
    .i_load_en  (w_load_en),
    .i_load_dat (i_seed_dat),
`endif
    .o_word     (w_word)
  );

  assign w_warm_last = (r_warm_cnt == CW'(WARM - 1));

  // Scan from the highest offset down so the nearest request at/after r_rr wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req[rr_idx(r_rr, i)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = rr_idx(r_rr, i);
      end
    end
  end

  assign w_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << w_gnt_idx;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= WARMUP;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_seed_wr)                           w_state_nxt = WARMUP;
    else if (r_state == WARMUP && w_warm_last) w_state_nxt = SERVE;
  end

  // A seed write pre-empts both warm-up stepping and any pending grant.
  always_comb begin
    w_step   = 1'b0;
    w_grant  = 1'b0;
    bus.busy = (r_state == WARMUP);
    if (!w_seed_wr) begin
      case (r_state)
        WARMUP:  w_step = 1'b1;
        SERVE: begin
          w_grant = w_gnt_vld;
          w_step  = w_gnt_vld;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_warm_cnt <= '0;
      r_rr       <= '0;
      r_ack      <= '0;
      r_rnd      <= '0;
    end else begin
      r_ack <= w_grant ? w_onehot : '0;
      if (w_grant) begin
        r_rnd <= w_word;
        r_rr  <= rr_idx(w_gnt_idx, 1);
      end
      if (w_seed_wr || r_state == SERVE || w_warm_last) r_warm_cnt <= '0;
      else                                              r_warm_cnt <= r_warm_cnt + CW'(1);
    end
  end

  assign bus.ack     = r_ack;
  assign bus.rnd_dat = r_rnd;

endmodule
